// File: rtl/cic_interp.sv
`default_nettype none
// ============================================================================
// Module   : cic_interp
// Brief    : CIC interpolator. Takes one signed low-rate sample per
//            R = 2^INTERP_BITS enabled clocks. ORDER comb stages run at the
//            slot rate, the result is zero-stuffed, and ORDER integrators run
//            at the i_en rate. All arithmetic is REG_WIDTH two's-complement
//            with wrap, which cancels between combs and integrators.
// Revision : 1.0 - initial release
// ============================================================================
module cic_interp #(
    parameter int I_WIDTH     = 16,
    parameter int ORDER       = 3,
    parameter int INTERP_BITS = 5,
    parameter int REG_WIDTH   = I_WIDTH + ORDER * INTERP_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [I_WIDTH-1:0]   i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [REG_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_strobe,
    output logic                 o_underrun
);

    logic                 w_phase_zero;
    logic                 w_slot;
    logic [REG_WIDTH-1:0] w_x;
    logic [REG_WIDTH-1:0] w_comb [ORDER+1];
    logic [REG_WIDTH-1:0] w_u;

    logic [REG_WIDTH-1:0] r_comb_d [ORDER];
    logic [REG_WIDTH-1:0] r_comb_out;
    logic                 r_stuff;
    logic [REG_WIDTH-1:0] r_integ [ORDER];
    logic                 r_valid;
    logic                 r_strobe;
    logic                 r_underrun;

    // Phase counter; with R=1 every enabled cycle is a slot, so no counter.
    generate
        if (INTERP_BITS > 0) begin : g_phase
            logic [INTERP_BITS-1:0] r_phase;

            // Advance the phase modulo R on every enabled cycle.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_phase <= '0;
                end else if (i_en) begin
                    r_phase <= r_phase + INTERP_BITS'(1);
                end
            end

            assign w_phase_zero = (r_phase == '0);
        end else begin : g_no_phase
            assign w_phase_zero = 1'b1;
        end
    endgenerate

    // Ready is gated by reset so upstream never sees a take during reset.
    assign w_slot  = i_en & w_phase_zero;
    assign o_ready = w_slot & i_rst_n;

    // A slot without a valid sample feeds a zero into the comb chain.
    assign w_x = i_valid ? REG_WIDTH'($signed(i_data)) : '0;

    // Comb chain: c_0 = x, c_k = c_{k-1} - d_k.
    always_comb begin
        w_comb[0] = w_x;
        for (int k = 1; k <= ORDER; k++) begin
            w_comb[k] = w_comb[k-1] - r_comb_d[k-1];
        end
    end

    // Comb delay states, comb output and slot-rate flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                r_comb_d[k] <= '0;
            end
            r_comb_out <= '0;
            r_stuff    <= 1'b0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else if (w_slot) begin
            for (int k = 0; k < ORDER; k++) begin
                r_comb_d[k] <= w_comb[k];
            end
            r_comb_out <= w_comb[ORDER];
            r_stuff    <= 1'b1;
            r_strobe   <= 1'b1;
            r_underrun <= ~i_valid;
        end else if (i_en) begin
            r_stuff    <= 1'b0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end
    end

    // Zero-stuffing: the comb result appears for exactly one enabled cycle.
    assign w_u = r_stuff ? r_comb_out : '0;

    // Integrator cascade; each stage adds the registered previous stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                r_integ[k] <= '0;
            end
        end else if (i_en) begin
            r_integ[0] <= r_integ[0] + w_u;
            for (int k = 1; k < ORDER; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
        end
    end

    // Output valid is a one-cycle-delayed copy of the enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_en;
        end
    end

    assign o_data     = r_integ[ORDER-1];
    assign o_valid    = r_valid;
    assign o_strobe   = r_strobe;
    assign o_underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_cic_interp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cic_interp
// Brief    : Self-checking bench for cic_interp. Three instances
//            (N=3/R=4, N=4/R=32, N=3/R=1) share stimulus; a convolution
//            model with the boxcar^N impulse response predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_interp;

    localparam int IW = 16;
    localparam int NA = 3, BA = 2, WA = IW + NA * BA;
    localparam int NB = 4, BB = 5, WB = IW + NB * BB;
    localparam int NC = 3, BC = 0, WC = IW + NC * BC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          en;
    logic          valid;
    logic [IW-1:0] din;

    logic          rdy_a, val_a, stb_a, und_a;
    logic [WA-1:0] dat_a;
    logic          rdy_b, val_b, stb_b, und_b;
    logic [WB-1:0] dat_b;
    logic          rdy_c, val_c, stb_c, und_c;
    logic [WC-1:0] dat_c;

    cic_interp #(.I_WIDTH(IW), .ORDER(NA), .INTERP_BITS(BA)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(din), .i_valid(valid),
        .o_ready(rdy_a), .o_data(dat_a), .o_valid(val_a), .o_strobe(stb_a), .o_underrun(und_a));
    cic_interp #(.I_WIDTH(IW), .ORDER(NB), .INTERP_BITS(BB)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(din), .i_valid(valid),
        .o_ready(rdy_b), .o_data(dat_b), .o_valid(val_b), .o_strobe(stb_b), .o_underrun(und_b));
    cic_interp #(.I_WIDTH(IW), .ORDER(NC), .INTERP_BITS(BC)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(din), .i_valid(valid),
        .o_ready(rdy_c), .o_data(dat_c), .o_valid(val_c), .o_strobe(stb_c), .o_underrun(und_c));

    typedef struct {
        longint y;
        logic   stb;
        logic   und;
    } exp_t;

    exp_t   sb0[$], sb1[$], sb2[$];
    int     ordv[3], rv[3], wv[3];
    longint h [3][256];
    int     hlen[3];
    longint xs [3][16384];
    int     nslot[3], nedge[3], ph[3];
    longint last_y[3];
    logic   rdy_exp[3];
    logic   rdy_obs[3];
    int     total = 0;
    int     bad   = 0;

    function automatic longint trunc(input longint y, input int w);
        return (y <<< (64 - w)) >>> (64 - w);
    endfunction

    task automatic build_h();
        longint tmp [256];
        int     nl;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 256; k++) h[i][k] = 0;
            h[i][0] = 1;
            hlen[i] = 1;
            for (int s = 0; s < ordv[i]; s++) begin
                nl = hlen[i] + rv[i] - 1;
                for (int k = 0; k < nl; k++) begin
                    tmp[k] = 0;
                    for (int m = 0; m < rv[i]; m++)
                        if (k - m >= 0 && k - m < hlen[i]) tmp[k] += h[i][k-m];
                end
                for (int k = 0; k < nl; k++) h[i][k] = tmp[k];
                hlen[i] = nl;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            nslot[i] = 0; nedge[i] = 0; ph[i] = 0; last_y[i] = 0;
        end
        sb0.delete(); sb1.delete(); sb2.delete();
    endtask

    // Reference: y(n) = sum_j x_j * h[n - N - j*R], truncated to REG_WIDTH.
    task automatic model_edge(input int i, input logic v, input logic [IW-1:0] d);
        exp_t   ex;
        longint y;
        int     base;
        ex.stb = (ph[i] == 0);
        ex.und = ex.stb && !v;
        if (ex.stb) begin
            if (nslot[i] >= 16384) begin
                $display("FAIL model_capacity: slots=%0d required below 16384", nslot[i]);
                $fatal(1);
            end
            xs[i][nslot[i]] = v ? longint'($signed(d)) : 64'sd0;
            nslot[i]++;
        end
        y    = 0;
        base = nedge[i] - ordv[i];
        if (base >= 0)
            for (int j = base / rv[i]; j >= 0 && (base - j * rv[i]) < hlen[i]; j--)
                if (j < nslot[i]) y += xs[i][j] * h[i][base - j * rv[i]];
        ex.y = trunc(y, wv[i]);
        last_y[i] = ex.y;
        case (i)
            0:       sb0.push_back(ex);
            1:       sb1.push_back(ex);
            default: sb2.push_back(ex);
        endcase
        nedge[i]++;
        ph[i] = (ph[i] + 1) % rv[i];
    endtask

    // One clock: drive at the falling edge, capture ready, run the model on
    // the rising edge, return at the next falling edge with outputs settled.
    task automatic tick(input logic e, input logic v, input logic [IW-1:0] d);
        en = e; valid = v; din = d;
        for (int i = 0; i < 3; i++) rdy_exp[i] = e && (ph[i] == 0);
        #1;
        rdy_obs[0] = rdy_a; rdy_obs[1] = rdy_b; rdy_obs[2] = rdy_c;
        @(posedge clk);
        if (e) for (int i = 0; i < 3; i++) model_edge(i, v, d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        en = 1'b1; valid = 1'b1; din = 16'd5;
        repeat (3) @(negedge clk);
        total++;
        if ({rdy_a, val_a, stb_a, und_a} !== 4'b0 || dat_a !== '0) begin
            bad++;
            $display("FAIL reset_a: rdy/val/stb/und=%b%b%b%b data=%0d required all 0", rdy_a, val_a, stb_a, und_a, dat_a);
        end
        total++;
        if ({rdy_b, val_b, stb_b, und_b, rdy_c, val_c, stb_c, und_c} !== 8'b0 || dat_b !== '0 || dat_c !== '0) begin
            bad++;
            $display("FAIL reset_bc: b=%b%b%b%b c=%b%b%b%b required all 0", rdy_b, val_b, stb_b, und_b, rdy_c, val_c, stb_c, und_c);
        end
        en = 1'b0; valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_impulse(input string tag);
        exp_t   ex;
        longint seq [40];
        longint ref_imp [40];
        longint sum;
        longint tbl [10];
        tbl = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
        for (int k = 0; k < 40; k++) ref_imp[k] = (k >= 3 && k < 13) ? tbl[k-3] : 64'sd0;
        sum = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, 1'b1, (k == 0) ? 16'd1 : 16'd0);
            if (k == 0) begin
                total++;
                if (rdy_obs[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_first_ready: ready=%b required 1", tag, rdy_obs[0]);
                end
            end
            seq[k] = longint'($signed(dat_a));
            sum += seq[k];
            total++;
            if (seq[k] !== ref_imp[k]) begin
                bad++;
                $display("FAIL %s_tap%0d: data=%0d required %0d", tag, k, seq[k], ref_imp[k]);
            end
            if (sb0.size() != 0) begin
                ex = sb0.pop_front();
                total++;
                if (seq[k] !== ex.y || stb_a !== ex.stb || und_a !== ex.und) begin
                    bad++;
                    $display("FAIL %s_sb: data=%0d stb=%b und=%b required %0d %b %b", tag, seq[k], stb_a, und_a, ex.y, ex.stb, ex.und);
                end
            end else begin
                total++; bad++;
                $display("FAIL %s_sb_empty: queue size=0 required 1", tag);
            end
        end
        total++;
        if (sum !== 64'sd64) begin
            bad++;
            $display("FAIL %s_sum: sum=%0d required 64", tag, sum);
        end
        sb1.delete(); sb2.delete();
    endtask

    task automatic test_step();
        exp_t ex;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 60; k++) begin
                tick(1'b1, 1'b1, (p == 0) ? IW'(1000) : IW'(-1000));
                ex = sb0.pop_front();
                total++;
                if (longint'($signed(dat_a)) !== ex.y || stb_a !== ex.stb || und_a !== ex.und) begin
                    bad++;
                    $display("FAIL step_sb: data=%0d stb=%b und=%b required %0d %b %b", $signed(dat_a), stb_a, und_a, ex.y, ex.stb, ex.und);
                end
            end
            total++;
            if (longint'($signed(dat_a)) !== ((p == 0) ? 64'sd16000 : -64'sd16000)) begin
                bad++;
                $display("FAIL step_final: data=%0d required %0d", $signed(dat_a), (p == 0) ? 16000 : -16000);
            end
        end
        sb1.delete(); sb2.delete();
    endtask

    task automatic test_handshake();
        exp_t          ex;
        logic          e, v;
        logic [IW-1:0] d;
        int            slots, strobes;
        slots = 0; strobes = 0;
        d = IW'($urandom_range(0, 65535));
        for (int c = 0; c < 150; c++) begin
            e = (c % 3 == 0);
            v = 1'($urandom_range(0, 1));
            tick(e, v, d);
            if (rdy_exp[0]) slots++;
            if (rdy_exp[0] && v) d = IW'($urandom_range(0, 65535));
            total++;
            if (rdy_obs[0] !== rdy_exp[0] || rdy_obs[2] !== e) begin
                bad++;
                $display("FAIL hs_ready c=%0d: a=%b c=%b required %b %b", c, rdy_obs[0], rdy_obs[2], rdy_exp[0], e);
            end
            total++;
            if (val_a !== e) begin
                bad++;
                $display("FAIL hs_valid c=%0d: o_valid=%b required %b", c, val_a, e);
            end
            if (stb_a === 1'b1) strobes++;
            if (e) begin
                ex = sb0.pop_front();
                total++;
                if (longint'($signed(dat_a)) !== ex.y || stb_a !== ex.stb || und_a !== ex.und) begin
                    bad++;
                    $display("FAIL hs_sb c=%0d: data=%0d stb=%b und=%b required %0d %b %b", c, $signed(dat_a), stb_a, und_a, ex.y, ex.stb, ex.und);
                end
            end else begin
                total++;
                if (longint'($signed(dat_a)) !== last_y[0] || stb_a !== 1'b0 || und_a !== 1'b0) begin
                    bad++;
                    $display("FAIL hs_hold c=%0d: data=%0d stb=%b und=%b required %0d 0 0", c, $signed(dat_a), stb_a, und_a, last_y[0]);
                end
            end
        end
        total++;
        if (strobes != slots || slots == 0) begin
            bad++;
            $display("FAIL hs_strobe_count: strobes=%0d required %0d (nonzero)", strobes, slots);
        end
        sb1.delete(); sb2.delete();
    endtask

    task automatic test_underrun();
        exp_t ex;
        int   slot_idx, pulses;
        logic v;
        slot_idx = 0; pulses = 0;
        for (int k = 0; k < 80; k++) begin
            v = !(ph[0] == 0 && slot_idx == 5);
            if (ph[0] == 0) slot_idx++;
            tick(1'b1, v, IW'(1000));
            if (und_a === 1'b1) pulses++;
            ex = sb0.pop_front();
            total++;
            if (longint'($signed(dat_a)) !== ex.y || stb_a !== ex.stb || und_a !== ex.und) begin
                bad++;
                $display("FAIL underrun_sb k=%0d: data=%0d stb=%b und=%b required %0d %b %b", k, $signed(dat_a), stb_a, und_a, ex.y, ex.stb, ex.und);
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL underrun_pulses: count=%0d required 1", pulses);
        end
        total++;
        if (longint'($signed(dat_a)) !== 64'sd16000) begin
            bad++;
            $display("FAIL underrun_recover: data=%0d required 16000", $signed(dat_a));
        end
        sb1.delete(); sb2.delete();
    endtask

    task automatic test_fullscale();
        exp_t          ex;
        int            bslots;
        logic [IW-1:0] d;
        bslots = 0;
        d = 16'h7FFF;
        for (int t = 0; t < 200 * 32; t++) begin
            if (ph[1] == 0) begin
                d = (bslots % 2 == 0) ? 16'h7FFF : 16'h8000;
                bslots++;
            end
            tick(1'b1, 1'b1, d);
            ex = sb1.pop_front();
            total++;
            if (longint'($signed(dat_b)) !== ex.y || stb_b !== ex.stb || und_b !== ex.und) begin
                bad++;
                $display("FAIL fullscale_sb t=%0d: data=%0d stb=%b und=%b required %0d %b %b", t, $signed(dat_b), stb_b, und_b, ex.y, ex.stb, ex.und);
            end
            sb0.delete(); sb2.delete();
        end
        total++;
        if (bslots != 200) begin
            bad++;
            $display("FAIL fullscale_slots: slots=%0d required 200", bslots);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 7; k++) tick(1'b1, 1'b1, IW'(1234));
        #2 rst_n = 1'b0;
        en = 1'b1;
        #1;
        total++;
        if ({rdy_a, val_a, stb_a, und_a} !== 4'b0 || dat_a !== '0) begin
            bad++;
            $display("FAIL async_reset_a: rdy/val/stb/und=%b%b%b%b data=%0d required all 0", rdy_a, val_a, stb_a, und_a, dat_a);
        end
        total++;
        if ({rdy_b, val_b, stb_b, und_b, rdy_c, val_c, stb_c, und_c} !== 8'b0 || dat_b !== '0 || dat_c !== '0) begin
            bad++;
            $display("FAIL async_reset_bc: b=%b%b%b%b c=%b%b%b%b required all 0", rdy_b, val_b, stb_b, und_b, rdy_c, val_c, stb_c, und_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        total++;
        if (rdy_a !== 1'b1) begin
            bad++;
            $display("FAIL async_release_ready: ready=%b required 1", rdy_a);
        end
        test_impulse("reimpulse");
    endtask

    task automatic test_r1();
        exp_t ex;
        logic e;
        for (int k = 0; k < 40; k++) begin
            e = (k >= 35) ? 1'b1 : 1'($urandom_range(0, 1));
            tick(e, 1'b1, IW'(1000));
            total++;
            if (rdy_obs[2] !== e) begin
                bad++;
                $display("FAIL r1_ready k=%0d: ready=%b required %b", k, rdy_obs[2], e);
            end
            if (e) begin
                ex = sb2.pop_front();
                total++;
                if (longint'($signed(dat_c)) !== ex.y || stb_c !== ex.stb || und_c !== ex.und) begin
                    bad++;
                    $display("FAIL r1_sb k=%0d: data=%0d stb=%b und=%b required %0d %b %b", k, $signed(dat_c), stb_c, und_c, ex.y, ex.stb, ex.und);
                end
            end
            sb0.delete(); sb1.delete();
        end
        total++;
        if (longint'($signed(dat_c)) !== 64'sd1000) begin
            bad++;
            $display("FAIL r1_dc_gain: data=%0d required 1000", $signed(dat_c));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; valid = 1'b0; din = '0;
        ordv[0] = NA; rv[0] = 1 << BA; wv[0] = WA;
        ordv[1] = NB; rv[1] = 1 << BB; wv[1] = WB;
        ordv[2] = NC; rv[2] = 1 << BC; wv[2] = WC;
        build_h();
        model_reset();
        @(negedge clk);
        test_reset();
        test_impulse("impulse");
        test_step();
        test_handshake();
        test_underrun();
        test_fullscale();
        test_async_reset();
        test_r1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cic_interp.md
Name: cic_interp

Overview:
- Cascaded integrator-comb interpolator: the transmit-side counterpart of the CIC decimator.
- Accepts low-rate signed samples through a valid/ready handshake, once every R = 2^INTERP_BITS enabled clocks.
- Runs ORDER comb stages at the low rate, zero-stuffs, then runs ORDER integrators at the i_en rate.
- Feeds the digital sigma-delta modulator / DAC path of the readout board.

Parameters:
I_WIDTH, 16, input sample width (signed two's complement)
ORDER, 3, number of comb and integrator stages (N), 1..6
INTERP_BITS, 5, interpolation ratio R = 2^INTERP_BITS; 0 allowed (R=1)
REG_WIDTH, I_WIDTH + ORDER*INTERP_BITS, internal and output register width

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_en  input  1  high-rate clock enable; all state frozen when low
i_data  input  I_WIDTH  signed low-rate sample
i_valid  input  1  i_data valid
o_ready  output  1  block takes a sample this cycle
o_data  output  REG_WIDTH  signed interpolated output
o_valid  output  1  o_data updated by the last edge (registered copy of i_en)
o_strobe  output  1  one-cycle pulse on each low-rate slot (registered)
o_underrun  output  1  one-cycle pulse: slot passed with i_valid low (registered)

Behaviour:
- Reset (i_rst_n low, async): phase counter, comb states, comb output reg, stuff flag, integrators, o_data, o_valid, o_strobe and o_underrun all clear to 0.
- Phase counter: INTERP_BITS wide; increments mod R on each i_en cycle. For INTERP_BITS=0 it is absent and the phase is always 0.
- Slot = i_en && phase==0. o_ready = slot, combinational, and 0 while in reset. The first enabled cycle after reset is a slot.
- Accept = slot && i_valid. i_valid with o_ready low is ignored; upstream holds the sample.
- On a slot edge:
  - comb input x = sign-extended i_data if accepted, else 0.
  - Comb chain evaluated combinationally: c_0 = x; c_k = c_{k-1} - d_k, where d_k is the stage-k state. Then d_k <= c_{k-1}.
  - comb_reg <= c_N; stuff <= 1; o_strobe <= 1; o_underrun <= !i_valid.
- On a non-slot enabled edge: stuff <= 0; o_strobe <= 0; o_underrun <= 0.
- Upsampler value u = stuff ? comb_reg : 0. This gives exactly one nonzero high-rate sample per slot, or one every cycle when R=1.
- Integrators, on each i_en edge: s_0 <= s_0 + u; s_k <= s_k + s_{k-1} (the registered previous stage). Every stage is registered.
- o_data = s_{N-1}. Latency: a sample accepted at edge E0 first affects o_data after edge E_N, i.e. N+1 enabled edges later.
- i_en low: nothing changes, o_ready=0, o_valid <= 0, strobes <= 0.
- Arithmetic: all REG_WIDTH, two's-complement wrap, no saturation. Comb/integrator wrap cancels, so the result is exact whenever the true output fits REG_WIDTH.
- DC gain is R^(N-1). Impulse response is the N-fold convolution of R ones; its length is N(R-1)+1 and its coefficients sum to R^N.
- Underrun: the slot is treated as a zero sample and the filter keeps running. There is no recovery state.
- Reset asserted mid-stream: immediate clear. After release, the first enabled cycle is a slot.

Test Plan:
- Impulse, ORDER=3, INTERP_BITS=2: accept i_data=1, then 0 each slot -> o_data = 0 until 4 enabled edges after acceptance, then 1,3,6,10,12,12,10,6,3,1, then 0 (sum 64).
- Step, ORDER=3, INTERP_BITS=2, i_data=1000 every slot -> o_data settles to 16000 after 10 outputs and holds; i_data=-1000 settles to -16000.
- Handshake: i_valid toggled randomly, i_en with 1-of-3 duty -> o_ready high only when i_en and phase 0; unaccepted samples are held; o_strobe count equals slot count; o_valid mirrors i_en delayed one cycle.
- Underrun: drop i_valid for one slot during a step of 1000 -> o_underrun pulses once, and the output matches the model with one zero sample injected.
- Full-scale wrap, I_WIDTH=16, ORDER=4, INTERP_BITS=5: i_data alternating 32767 / -32768 for 200 slots -> o_data bit-exact to the reference model, with no mismatch despite internal wrap.
- Async reset mid-stream: pulse i_rst_n low between edges -> all outputs 0 immediately. The first enabled cycle after release has o_ready=1, and the impulse test repeats exactly. INTERP_BITS=0 -> o_ready equals i_en and the DC gain is 1.
